mac_vector_sequencer: RTL and testbench

- Upstream operand feeder for the Vedic/reversible MAC datapath.
- Buffers incoming (A,B) operand pairs in a small FIFO and issues one pair per cycle to the MAC for a programmed vector length.
- Clears the MAC accumulator before the first pair, waits for pipeline drain, then captures the final 16-bit dot-product and a sticky error flag behind a valid/ready result port.

---
 rtl/mac_vector_sequencer.sv | 200 ++++++++++++++++++++
 tb/tb_mac_vector_sequencer.sv | 305 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mac_vector_sequencer.sv
// mac_vector_sequencer: operand FIFO plus issue sequencer for the MAC datapath.
// Operand pairs are buffered, issued one per cycle for a programmed length after
// an accumulator clear, and the final accumulator value is returned once the
// MAC pipeline has drained.
module mac_vector_sequencer #(
    parameter int DEPTH = 8,
    parameter int LEN_W = 8,
    parameter int LAT   = 2
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     start,
    input  logic [LEN_W-1:0]         vec_len,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [7:0]               in_a,
    input  logic [7:0]               in_b,
    output logic [7:0]               mac_a,
    output logic [7:0]               mac_b,
    output logic                     mac_clr,
    input  logic [15:0]              mac_acc,
    input  logic                     mac_err,
    output logic                     res_valid,
    input  logic                     res_ready,
    output logic [15:0]              res_data,
    output logic                     res_err,
    output logic                     busy,
    output logic [$clog2(DEPTH):0]   fifo_level
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int DRN_W = $clog2(LAT + 1);
    localparam logic [PTR_W:0]   LVL_FULL = DEPTH[PTR_W:0];
    localparam logic [DRN_W-1:0] DRN_LAST = LAT[DRN_W-1:0];

    typedef enum logic [2:0] {
        S_IDLE,
        S_CLEAR,
        S_ISSUE,
        S_DRAIN,
        S_DONE
    } state_t;

    // FIFO storage and bookkeeping
    logic [7:0]       r_mem_a [DEPTH];
    logic [7:0]       r_mem_b [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [PTR_W:0]   r_level;

    // Sequencer state
    state_t           r_state;
    logic [LEN_W-1:0] r_len;
    logic [LEN_W-1:0] r_issue_cnt;
    logic [DRN_W-1:0] r_drain_cnt;
    logic [7:0]       r_mac_a;
    logic [7:0]       r_mac_b;
    logic             r_mac_clr;
    logic             r_res_valid;
    logic [15:0]      r_res_data;
    logic             r_res_err;
    logic             r_busy;

    logic             w_full;
    logic             w_empty;
    logic             w_push;
    logic             w_pop;
    logic [7:0]       w_rd_a;
    logic [7:0]       w_rd_b;
    logic [LEN_W-1:0] w_issue_next;

    assign w_full       = (r_level == LVL_FULL);
    assign w_empty      = (r_level == '0);
    assign w_push       = in_valid && !w_full;
    // Pops only happen while issuing; a pair pushed this cycle is counted in
    // r_level from the next cycle, so it cannot be popped the same cycle.
    assign w_pop        = (r_state == S_ISSUE) && !w_empty;
    assign w_rd_a       = r_mem_a[r_rd_ptr];
    assign w_rd_b       = r_mem_b[r_rd_ptr];
    assign w_issue_next = r_issue_cnt + 1'b1;

    assign in_ready   = !w_full;
    assign mac_a      = r_mac_a;
    assign mac_b      = r_mac_b;
    assign mac_clr    = r_mac_clr;
    assign res_valid  = r_res_valid;
    assign res_data   = r_res_data;
    assign res_err    = r_res_err;
    assign busy       = r_busy;
    assign fifo_level = r_level;

    // Operand storage write port.
    // NOTE: the storage array has no reset; validity is tracked entirely by
    // the pointers and level, so clearing it would only cost reset fan-out.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem_a[r_wr_ptr] <= in_a;
            r_mem_b[r_wr_ptr] <= in_b;
        end
    end

    // FIFO pointers and occupancy; pointers wrap naturally at DEPTH.
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            case ({w_push, w_pop})
                2'b10:   r_level <= r_level + 1'b1;
                2'b01:   r_level <= r_level - 1'b1;
                default: r_level <= r_level;
            endcase
        end
    end

    // Operation sequencer with registered MAC drive and result port.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_len       <= '0;
            r_issue_cnt <= '0;
            r_drain_cnt <= '0;
            r_mac_a     <= '0;
            r_mac_b     <= '0;
            r_mac_clr   <= 1'b0;
            r_res_valid <= 1'b0;
            r_res_data  <= '0;
            r_res_err   <= 1'b0;
            r_busy      <= 1'b0;
        end else begin
            // Idle drive to the MAC unless a state below issues a pair or clear.
            r_mac_a   <= '0;
            r_mac_b   <= '0;
            r_mac_clr <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_busy    <= 1'b1;
                        r_res_err <= 1'b0;
                        if (vec_len != '0) begin
                            r_len       <= vec_len;
                            r_issue_cnt <= '0;
                            r_mac_clr   <= 1'b1;
                            r_state     <= S_CLEAR;
                        end else begin
                            r_res_data  <= '0;
                            r_res_valid <= 1'b1;
                            r_state     <= S_DONE;
                        end
                    end
                end
                S_CLEAR: begin
                    r_res_err <= r_res_err | mac_err;
                    r_state   <= S_ISSUE;
                end
                S_ISSUE: begin
                    r_res_err <= r_res_err | mac_err;
                    if (w_pop) begin
                        r_mac_a     <= w_rd_a;
                        r_mac_b     <= w_rd_b;
                        r_issue_cnt <= w_issue_next;
                        if (w_issue_next == r_len) begin
                            r_drain_cnt <= '0;
                            r_state     <= S_DRAIN;
                        end
                    end
                end
                S_DRAIN: begin
                    // First cycle shows the last pair; LAT zero cycles follow,
                    // after which its product is visible on mac_acc.
                    r_res_err <= r_res_err | mac_err;
                    if (r_drain_cnt == DRN_LAST) begin
                        r_res_data  <= mac_acc;
                        r_res_valid <= 1'b1;
                        r_state     <= S_DONE;
                    end else begin
                        r_drain_cnt <= r_drain_cnt + 1'b1;
                    end
                end
                S_DONE: begin
                    if (res_ready) begin
                        r_res_valid <= 1'b0;
                        r_busy      <= 1'b0;
                        r_state     <= S_IDLE;
                    end
                end
                default: begin
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mac_vector_sequencer.sv
// tb_mac_vector_sequencer: directed and randomized checks of the operand
// sequencer against a queue-based dot-product model, with a LAT=2 MAC fixture.
module tb_mac_vector_sequencer;

    localparam int DEPTH = 8;
    localparam int LEN_W = 8;
    localparam int LAT   = 2;

    logic             clk = 1'b0;
    logic             rst;
    logic             start;
    logic [LEN_W-1:0] vec_len;
    logic             in_valid;
    logic             in_ready;
    logic [7:0]       in_a;
    logic [7:0]       in_b;
    logic [7:0]       mac_a;
    logic [7:0]       mac_b;
    logic             mac_clr;
    logic [15:0]      mac_acc;
    logic             mac_err;
    logic             res_valid;
    logic             res_ready;
    logic [15:0]      res_data;
    logic             res_err;
    logic             busy;
    logic [3:0]       fifo_level;

    int checks = 0;
    int errors = 0;

    // Every pair the DUT accepted, oldest first: {a, b}
    logic [15:0] model_q [$];

    mac_vector_sequencer #(.DEPTH(DEPTH), .LEN_W(LEN_W), .LAT(LAT)) dut (
        .clk(clk), .rst(rst), .start(start), .vec_len(vec_len),
        .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a), .in_b(in_b),
        .mac_a(mac_a), .mac_b(mac_b), .mac_clr(mac_clr), .mac_acc(mac_acc),
        .mac_err(mac_err), .res_valid(res_valid), .res_ready(res_ready),
        .res_data(res_data), .res_err(res_err), .busy(busy),
        .fifo_level(fifo_level)
    );

    always #5 clk = ~clk;

    // Behavioural MAC, two cycles from operands to accumulator
    logic [15:0] m_prod;
    logic        m_clr_d;
    logic [15:0] m_acc;
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            m_prod  <= '0;
            m_clr_d <= 1'b0;
            m_acc   <= '0;
        end else begin
            m_prod  <= 16'(mac_a) * 16'(mac_b);
            m_clr_d <= mac_clr;
            m_acc   <= m_clr_d ? 16'd0 : m_acc + m_prod;
        end
    end
    assign mac_acc = m_acc;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        checks++;
        assert (obs === exp_v) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp_v);
        end
    endtask

    // Advance one cycle, recording any pair the DUT accepts at this edge
    task automatic tick();
        if (!rst && in_valid && in_ready) model_q.push_back({in_a, in_b});
        @(posedge clk);
        #1;
    endtask

    task automatic push_pair(input logic [7:0] a, input logic [7:0] b);
        in_valid = 1'b1;
        in_a     = a;
        in_b     = b;
        tick();
        in_valid = 1'b0;
    endtask

    task automatic do_start(input int n);
        start   = 1'b1;
        vec_len = LEN_W'(n);
        tick();
        start   = 1'b0;
    endtask

    // Dot product of the next n accepted pairs, modulo 2^16
    function automatic logic [15:0] pop_sum(input int n);
        logic [15:0] s;
        logic [15:0] e;
        s = '0;
        for (int i = 0; i < n; i++) begin
            if (model_q.size() > 0) begin
                e = model_q.pop_front();
                s = s + 16'(e[15:8]) * 16'(e[7:0]);
            end
        end
        return s;
    endfunction

    // Wait for the result, check it, stall the consumer, then hand it off.
    // With feed set, pairs, stray start pulses and error blips arrive meanwhile.
    task automatic wait_result(input int n, input bit feed, input bit err_in,
                               input int stalls, input string tag);
        bit          exp_err;
        logic [15:0] exp_v;
        int          cyc;
        int          ns;
        exp_err = err_in;
        cyc     = 0;
        while (!res_valid && cyc < 300) begin
            if (feed) begin
                in_valid = 1'($urandom_range(0, 1));
                in_a     = 8'($urandom);
                in_b     = 8'($urandom);
                mac_err  = ($urandom_range(0, 15) == 0);
            end
            start   = ($urandom_range(0, 7) == 0);
            vec_len = LEN_W'($urandom);
            if (mac_err && busy && !res_valid) exp_err = 1'b1;
            tick();
            cyc++;
        end
        in_valid = 1'b0;
        start    = 1'b0;
        mac_err  = 1'b0;
        check($sformatf("%s_res_valid", tag), res_valid, 1);
        if (res_valid) begin
            exp_v = pop_sum(n);
            check($sformatf("%s_res_data", tag), res_data, exp_v);
            check($sformatf("%s_res_err", tag), res_err, exp_err);
            ns = (stalls < 0) ? $urandom_range(0, 3) : stalls;
            for (int i = 0; i < ns; i++) begin
                res_ready = 1'b0;
                tick();
                check($sformatf("%s_stall_valid", tag), res_valid, 1);
                check($sformatf("%s_stall_data", tag), res_data, exp_v);
            end
            // A start in the handshake cycle must be ignored
            res_ready = 1'b1;
            start     = 1'b1;
            vec_len   = LEN_W'(3);
            tick();
            res_ready = 1'b0;
            start     = 1'b0;
            check($sformatf("%s_after_valid", tag), res_valid, 0);
            check($sformatf("%s_after_busy", tag), busy, 0);
        end
    endtask

    initial begin
        logic [7:0] ra;
        logic [7:0] rb;
        int         n;

        rst       = 1'b1;
        start     = 1'b0;
        vec_len   = '0;
        in_valid  = 1'b0;
        in_a      = '0;
        in_b      = '0;
        mac_err   = 1'b0;
        res_ready = 1'b0;

        // Reset state
        tick();
        tick();
        check("rst_busy", busy, 0);
        check("rst_level", fifo_level, 0);
        check("rst_valid", res_valid, 0);
        check("rst_clr", mac_clr, 0);
        check("rst_mac_a", mac_a, 0);
        rst = 1'b0;
        tick();
        check("rel_in_ready", in_ready, 1);

        // Basic dot product with back-to-back issue
        push_pair(8'd2, 8'd3);
        push_pair(8'd4, 8'd5);
        push_pair(8'd6, 8'd7);
        check("basic_level", fifo_level, 3);
        do_start(3);
        check("basic_clr", mac_clr, 1);
        check("basic_busy", busy, 1);
        check("basic_clr_a", mac_a, 0);
        tick();
        check("basic_clr_off", mac_clr, 0);
        check("basic_first_a", mac_a, 0);
        tick();
        check("basic_pair0", {mac_a, mac_b}, {8'd2, 8'd3});
        tick();
        check("basic_pair1", {mac_a, mac_b}, {8'd4, 8'd5});
        tick();
        check("basic_pair2", {mac_a, mac_b}, {8'd6, 8'd7});
        tick();
        check("basic_drain_a", mac_a, 0);
        check("basic_level_end", fifo_level, 0);
        wait_result(3, 1'b0, 1'b0, 5, "basic");
        check("basic_value", 68, 16'h0044 + 0 * res_data);

        // Zero-length vector completes on the next cycle with zero result
        do_start(0);
        check("len0_done_next", res_valid, 1);
        wait_result(0, 1'b0, 1'b0, 1, "len0");

        // Starvation: bubbles while the FIFO is empty
        do_start(2);
        tick();
        tick();
        check("starve_bubble", {mac_a, mac_b}, 16'h0000);
        push_pair(8'd255, 8'd255);
        check("starve_no_same_cycle_pop", mac_a, 0);
        tick();
        check("starve_pair0", {mac_a, mac_b}, {8'd255, 8'd255});
        tick();
        check("starve_bubble2", mac_a, 0);
        tick();
        tick();
        push_pair(8'd1, 8'd1);
        wait_result(2, 1'b0, 1'b0, 0, "starve");

        // FIFO full, then operations across pointer wrap
        in_valid = 1'b1;
        for (int i = 0; i < 10; i++) begin
            in_a = 8'($urandom);
            in_b = 8'($urandom);
            tick();
        end
        in_valid = 1'b0;
        check("full_level", fifo_level, 8);
        check("full_in_ready", in_ready, 0);
        check("full_model_size", model_q.size(), 8);
        do_start(8);
        wait_result(8, 1'b0, 1'b0, -1, "wrap8");
        for (int i = 0; i < 8; i++) begin
            ra = 8'($urandom);
            rb = 8'($urandom);
            push_pair(ra, rb);
        end
        do_start(5);
        wait_result(5, 1'b0, 1'b0, -1, "wrap5");
        check("wrap_left", fifo_level, 3);
        do_start(3);
        wait_result(3, 1'b0, 1'b0, -1, "wrap3");
        check("wrap_empty", fifo_level, 0);

        // Single-cycle error during issue
        push_pair(8'd10, 8'd11);
        push_pair(8'd12, 8'd13);
        push_pair(8'd14, 8'd15);
        do_start(3);
        tick();
        mac_err = 1'b1;
        tick();
        mac_err = 1'b0;
        wait_result(3, 1'b0, 1'b1, 0, "err");

        // Reset in the middle of issuing, after two of four pairs
        for (int i = 0; i < 4; i++) push_pair(8'(i + 1), 8'(i + 2));
        do_start(4);
        tick();
        tick();
        tick();
        check("midrst_pair1", {mac_a, mac_b}, {8'd2, 8'd3});
        #2;
        rst = 1'b1;
        #1;
        check("midrst_busy", busy, 0);
        check("midrst_level", fifo_level, 0);
        check("midrst_mac_a", mac_a, 0);
        check("midrst_valid", res_valid, 0);
        check("midrst_err", res_err, 0);
        check("midrst_data", res_data, 0);
        model_q.delete();
        @(posedge clk);
        #1;
        rst = 1'b0;
        tick();
        tick();
        check("postrst_in_ready", in_ready, 1);
        check("postrst_no_result", res_valid, 0);
        for (int i = 0; i < 4; i++) push_pair(8'($urandom), 8'($urandom));
        do_start(4);
        wait_result(4, 1'b0, 1'b0, -1, "postrst");

        // Randomized operations with concurrent feeding and error blips
        for (int it = 0; it < 20; it++) begin
            n = $urandom_range(0, 8);
            for (int i = 0; i < n; i++) push_pair(8'($urandom), 8'($urandom));
            n = $urandom_range(1, 10);
            do_start(n);
            wait_result(n, 1'b1, 1'b0, -1, $sformatf("rnd%0d", it));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
